// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin sequencer around one shared combinational ALU.
// Each accepted op gets one EXEC cycle on the ALU and its result is returned over valid/ready.
module alu_share_ctrl #(
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned DW  = 32,
    localparam int unsigned OPW = 3,
    localparam int unsigned FW  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [DW-1:0]        req0_a,
    input  logic [DW-1:0]        req0_b,
    input  logic [OPW-1:0]       req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [DW-1:0]        req1_a,
    input  logic [DW-1:0]        req1_b,
    input  logic [OPW-1:0]       req1_op,
    output logic                 resp0_valid,
    input  logic                 resp0_ready,
    output logic [DW-1:0]        resp0_data,
    output logic [FW-1:0]        resp0_flags,
    output logic                 resp1_valid,
    input  logic                 resp1_ready,
    output logic [DW-1:0]        resp1_data,
    output logic [FW-1:0]        resp1_flags,
    output logic [DW-1:0]        alu_busA,
    output logic [DW-1:0]        alu_busB,
    output logic [OPW-1:0]       alu_control,
    input  logic [DW-1:0]        alu_dataOut,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    input  logic                 alu_carryout,
    input  logic                 alu_negative,
    output logic [FW-1:0]        status_flags,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam logic [OPW-1:0] OP_NOP = OPW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q, owner_q;
    logic [DW-1:0]        bus_a_q, bus_b_q, result_q;
    logic [OPW-1:0]       ctrl_q;
    logic [FW-1:0]        rflags_q, status_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 resp0_valid_q, resp1_valid_q;

    logic                 gnt0_c, gnt1_c, accept_c, capture_c, resp_done_c;
    logic [DW-1:0]        cap_data_c;
    logic [FW-1:0]        cap_flags_c;

    // Next state, round-robin grant and per-state strobes
    always_comb begin
        state_d     = state_q;
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        resp_done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    gnt0_c = last_grant_q;
                    gnt1_c = ~last_grant_q;
                end else begin
                    gnt0_c = req0_valid;
                    gnt1_c = req1_valid;
                end
                accept_c = gnt0_c | gnt1_c;
                if (accept_c) state_d = S_EXEC;
            end
            S_EXEC: begin
                capture_c = 1'b1;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_done_c = owner_q ? resp1_ready : resp0_ready;
                if (resp_done_c) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A NOP returns all-zero result and flags regardless of what the ALU shows
    always_comb begin
        cap_data_c  = alu_dataOut;
        cap_flags_c = {alu_negative, alu_zero, alu_carryout, alu_overflow};
        if (ctrl_q == OP_NOP) begin
            cap_data_c  = '0;
            cap_flags_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ALU drive registers double as the operand latch; they are cleared when EXEC ends
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            bus_a_q       <= '0;
            bus_b_q       <= '0;
            ctrl_q        <= '0;
            result_q      <= '0;
            rflags_q      <= '0;
            status_q      <= '0;
            count_q       <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else if (accept_c) begin
            owner_q      <= gnt1_c;
            last_grant_q <= gnt1_c;
            bus_a_q      <= gnt1_c ? req1_a  : req0_a;
            bus_b_q      <= gnt1_c ? req1_b  : req0_b;
            ctrl_q       <= gnt1_c ? req1_op : req0_op;
        end else if (capture_c) begin
            bus_a_q       <= '0;
            bus_b_q       <= '0;
            ctrl_q        <= '0;
            result_q      <= cap_data_c;
            rflags_q      <= cap_flags_c;
            status_q      <= cap_flags_c;
            count_q       <= count_q + CNT_WIDTH'(1);
            resp0_valid_q <= ~owner_q;
            resp1_valid_q <= owner_q;
        end else if (resp_done_c) begin
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end
    end

    assign req0_ready   = gnt0_c & ~reset;
    assign req1_ready   = gnt1_c & ~reset;
    assign resp0_valid  = resp0_valid_q;
    assign resp1_valid  = resp1_valid_q;
    assign resp0_data   = result_q;
    assign resp1_data   = result_q;
    assign resp0_flags  = rflags_q;
    assign resp1_flags  = rflags_q;
    assign alu_busA     = bus_a_q;
    assign alu_busB     = bus_b_q;
    assign alu_control  = ctrl_q;
    assign status_flags = status_q;
    assign op_count     = count_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: ALU stand-in, transaction-level reference model with per-cycle compare,
// and directed scenarios with hand-computed results.
module tb_alu_share_ctrl;

    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    logic [2:0]    req0_op, req1_op;
    logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0]   resp0_data, resp1_data;
    logic [3:0]    resp0_flags, resp1_flags;
    logic [31:0]   alu_busA, alu_busB, alu_dataOut;
    logic [2:0]    alu_control;
    logic          alu_zero, alu_overflow, alu_carryout, alu_negative;
    logic [3:0]    status_flags;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data), .resp0_flags(resp0_flags),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data), .resp1_flags(resp1_flags),
        .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_control(alu_control), .alu_dataOut(alu_dataOut),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carryout(alu_carryout), .alu_negative(alu_negative),
        .status_flags(status_flags), .op_count(op_count)
    );

    // ALU stand-in, returns {N, Z, C, V, data}; NOP shows garbage so the block must zero it
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] w;
        logic [31:0] d;
        logic        c, v;
        c = 1'b0; v = 1'b0; d = 32'd0; w = 33'd0;
        case (op)
            3'd0: return {4'hF, 32'hDEAD_BEEF};
            3'd1: begin
                w = {1'b0, a} + {1'b0, b};
                d = w[31:0]; c = w[32];
                v = (a[31] == b[31]) && (d[31] != a[31]);
            end
            3'd2: begin
                w = {1'b0, a} + {1'b0, ~b} + 33'd1;
                d = w[31:0]; c = w[32];
                v = (a[31] != b[31]) && (d[31] != a[31]);
            end
            3'd3: d = a & b;
            3'd4: d = a | b;
            3'd5: d = a ^ b;
            3'd6: d = {31'd0, $signed(a) < $signed(b)};
            default: d = a << b[1:0];
        endcase
        return {d[31], d == 32'd0, c, v, d};
    endfunction

    assign {alu_negative, alu_zero, alu_carryout, alu_overflow, alu_dataOut} = alu_fn(alu_busA, alu_busB, alu_control);

    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: at most one transaction in flight, tracked as accepted / result-ready
    bit          m_busy = 1'b0, m_done = 1'b0;
    int          m_owner = 0, m_last = 1;
    logic [31:0] m_a, m_b, m_data = 32'd0;
    logic [2:0]  m_op;
    logic [3:0]  m_flags = 4'd0, m_status = 4'd0;
    logic [CW-1:0] m_cnt = '0;

    always @(posedge clk) begin : model
        int g;
        logic [35:0] r;
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_last = 1; m_cnt = '0;
            m_data = 32'd0; m_flags = 4'd0; m_status = 4'd0;
        end else if (!m_busy) begin
            g = pick(req0_valid, req1_valid, m_last);
            if (g >= 0) begin
                m_busy = 1'b1; m_done = 1'b0; m_owner = g; m_last = g;
                m_a  = (g == 1) ? req1_a  : req0_a;
                m_b  = (g == 1) ? req1_b  : req0_b;
                m_op = (g == 1) ? req1_op : req0_op;
            end
        end else if (!m_done) begin
            r = (m_op == 3'd0) ? 36'd0 : alu_fn(m_a, m_b, m_op);
            m_data = r[31:0]; m_flags = r[35:32]; m_status = r[35:32];
            m_cnt = CW'(m_cnt + 1'b1);
            m_done = 1'b1;
        end else if ((m_owner == 0 && resp0_ready) || (m_owner == 1 && resp1_ready)) begin
            m_busy = 1'b0;
        end
    end

    always @(posedge clk) begin : compare
        int   g;
        logic ex, rv0, rv1;
        #1;
        if (chk_en) begin
            g   = (!reset && !m_busy) ? pick(req0_valid, req1_valid, m_last) : -1;
            ex  = m_busy && !m_done;
            rv0 = m_busy && m_done && (m_owner == 0);
            rv1 = m_busy && m_done && (m_owner == 1);
            chk("req0_ready", 32'(req0_ready), 32'(g == 0));
            chk("req1_ready", 32'(req1_ready), 32'(g == 1));
            chk("alu_busA", alu_busA, ex ? m_a : 32'd0);
            chk("alu_busB", alu_busB, ex ? m_b : 32'd0);
            chk("alu_control", 32'(alu_control), ex ? 32'(m_op) : 32'd0);
            chk("resp0_valid", 32'(resp0_valid), 32'(rv0));
            chk("resp1_valid", 32'(resp1_valid), 32'(rv1));
            if (rv0) begin
                chk("resp0_data", resp0_data, m_data);
                chk("resp0_flags", 32'(resp0_flags), 32'(m_flags));
            end
            if (rv1) begin
                chk("resp1_data", resp1_data, m_data);
                chk("resp1_flags", 32'(resp1_flags), 32'(m_flags));
            end
            chk("status_flags", 32'(status_flags), 32'(m_status));
            chk("op_count", 32'(op_count), 32'(m_cnt));
        end
    end

    // Handshake log, sampled late in the low phase so it sees what the next edge will act on
    typedef struct { int id; logic [31:0] d; logic [3:0] f; logic [CW-1:0] c; } resp_t;
    int    gq[$];
    resp_t rq[$];

    always begin
        @(negedge clk);
        #4;
        if (!reset) begin
            if (req0_valid && req0_ready) gq.push_back(0);
            if (req1_valid && req1_ready) gq.push_back(1);
            if (resp0_valid && resp0_ready) rq.push_back('{0, resp0_data, resp0_flags, op_count});
            if (resp1_valid && resp1_ready) rq.push_back('{1, resp1_data, resp1_flags, op_count});
        end
    end

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bit acc;
        acc = 1'b0;
        if (id == 1) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        else         begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = (id == 1) ? req1_ready : req0_ready;
            @(negedge clk);
        end
        if (id == 1) req1_valid = 1'b0;
        else         req0_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input int id, output int n, output logic [31:0] d, output logic [3:0] f);
        n = 0;
        while (n < 20 && !((id == 1) ? resp1_valid : resp0_valid)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("resp_timeout", 32'd0, 32'd1);
        d = (id == 1) ? resp1_data  : resp0_data;
        f = (id == 1) ? resp1_flags : resp0_flags;
    endtask

    task automatic handshake(input int id);
        if (id == 1) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        @(negedge clk);
        if (id == 1) resp1_ready = 1'b0; else resp0_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          n;
        logic [31:0] d;
        logic [3:0]  f;
        logic [CW-1:0] exp_cnt [4];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};

        reset = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_status", 32'(status_flags), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Signed overflow on ADD
        send(0, 32'h7FFF_FFFF, 32'd1, 3'd1);
        chk("add_ctrl_exec", 32'(alu_control), 32'd1);
        wait_resp(0, n, d, f);
        chk("add_latency", 32'(n), 32'd1);
        chk("add_data", d, 32'h8000_0000);
        chk("add_flags", 32'(f), 32'b1001);
        chk("add_count", 32'(op_count), 32'd1);
        handshake(0);

        // Reset during EXEC drops the op and restores the req0-first pointer
        send(0, 32'd3, 32'd4, 3'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_resp0", 32'(resp0_valid), 32'd0);
        chk("rst_mid_count", 32'(op_count), 32'd0);
        chk("rst_mid_ctrl", 32'(alu_control), 32'd0);
        reset = 1'b0;

        // Both requesters hold valid continuously
        gq.delete(); rq.delete();
        req0_a = 32'd5;      req0_b = 32'd5;      req0_op = 3'd2;
        req1_a = 32'hF0F0;   req1_b = 32'h0FF0;   req1_op = 3'd5;
        resp0_ready = 1'b1;  resp1_ready = 1'b1;
        req0_valid = 1'b1;   req1_valid = 1'b1;
        for (int i = 0; i < 40 && gq.size() < 4; i++) @(negedge clk);
        req0_valid = 1'b0;   req1_valid = 1'b0;
        repeat (6) @(negedge clk);
        resp0_ready = 1'b0;  resp1_ready = 1'b0;
        chk("rr_grant_count", 32'(gq.size()), 32'd4);
        chk("rr_resp_count", 32'(rq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) chk("rr_grant_order", 32'(gq[i]), 32'(i % 2));
            if (i < rq.size()) begin
                chk("rr_resp_owner", 32'(rq[i].id), 32'(i % 2));
                chk("rr_resp_count_seq", 32'(rq[i].c), 32'(exp_cnt[i]));
                if (i % 2 == 0) begin
                    chk("rr_sub_data", rq[i].d, 32'd0);
                    chk("rr_sub_zflag", 32'(rq[i].f[2]), 32'd1);
                end else begin
                    chk("rr_xor_data", rq[i].d, 32'h0000_FF00);
                    chk("rr_xor_flags", 32'(rq[i].f), 32'd0);
                end
            end
        end

        // Held-off response with req0 pending behind it
        send(1, 32'hF0F0_1234, 32'hFF00_FF00, 3'd3);
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd6; req0_op = 3'd0;
        wait_resp(1, n, d, f);
        chk("bp_latency", 32'(n), 32'd1);
        chk("bp_flags", 32'(f), 32'b1000);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", 32'(resp1_valid), 32'd1);
            chk("bp_data_hold", resp1_data, 32'hF000_1200);
            chk("bp_req0_blocked", 32'(req0_ready), 32'd0);
            chk("bp_alu_nop", 32'(alu_control), 32'd0);
            @(negedge clk);
        end
        chk("bp_count_wrapped", 32'(op_count), 32'd1);
        handshake(1);
        chk("bp_idle_after_hs", 32'(req0_ready), 32'd1);

        // NOP is counted and returns zeros
        send(0, 32'd5, 32'd6, 3'd0);
        wait_resp(0, n, d, f);
        chk("nop_data", d, 32'd0);
        chk("nop_flags", 32'(f), 32'd0);
        chk("nop_count", 32'(op_count), 32'd2);
        handshake(0);

        // Shift by busB[1:0]
        send(1, 32'd1, 32'd2, 3'd7);
        chk("shift_busB", alu_busB, 32'd2);
        chk("shift_ctrl", 32'(alu_control), 32'd7);
        wait_resp(1, n, d, f);
        chk("shift_data", d, 32'd4);
        chk("shift_count", 32'(op_count), 32'd3);
        handshake(1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
